// File: rtl/parking_pkg.sv
// Shared types and helpers for the parking-lot occupancy controller.
package parking_pkg;

  typedef enum logic [1:0] {CLOSED, OPEN, CLOSING} gate_state_t;

  // Timer must hold max(open, close) - 1; never narrower than one bit.
  function automatic int timer_w(input int open_cyc, input int close_cyc);
    int m;
    m = (open_cyc > close_cyc) ? open_cyc : close_cyc;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/parking_lot_ctrl_edge_sync.sv
// Two-flop synchroniser for an async sensor level plus a one-cycle rising-edge pulse.
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  logic s1, s2, s2_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s2_d <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      s2_d <= s2;
    end
  end

  assign pulse = s2 & ~s2_d;

endmodule

// File: rtl/parking_lot_ctrl.sv
// Occupancy counter with saturating entry/exit handling and one timed barrier FSM per lane.
module parking_lot_ctrl
  import parking_pkg::*;
#(
  parameter int CAPACITY     = 10,
  parameter int INIT_COUNT   = 5,
  parameter int CNT_W        = 4,
  parameter int OPEN_CYCLES  = 8,
  parameter int CLOSE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             entry,
  input  logic             exit,
  output logic [CNT_W-1:0] num,
  output logic             full,
  output logic             empty,
  output logic             entry_gate_open,
  output logic             exit_gate_open,
  output logic             reject,
  output logic             underflow
);

  localparam int TW = timer_w(OPEN_CYCLES, CLOSE_CYCLES);
  localparam logic [CNT_W-1:0] CAP_V  = CNT_W'(CAPACITY);
  localparam logic [CNT_W-1:0] INIT_V = CNT_W'(INIT_COUNT);
  localparam logic [TW-1:0]    OPEN_LD  = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0]    CLOSE_LD = TW'(CLOSE_CYCLES - 1);

  logic       ent_p, ext_p;
  logic [1:0] acc;
  logic [1:0] gate_open;

  edge_sync u_ent (.clk(clk), .rst_n(rst_n), .din(entry), .pulse(ent_p));
  edge_sync u_ext (.clk(clk), .rst_n(rst_n), .din(exit),  .pulse(ext_p));

  assign full  = (num == CAP_V);
  assign empty = (num == '0);

  // Simultaneous entry+exit is always accepted on both lanes, even at the limits.
  assign acc[0] = ent_p & (ext_p | ~full);
  assign acc[1] = ext_p & (ent_p | ~empty);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num       <= INIT_V;
      reject    <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ent_p && !ext_p && !full)
        num <= num + CNT_W'(1);
      else if (ext_p && !ent_p && !empty)
        num <= num - CNT_W'(1);
      reject    <= ent_p & ~ext_p & full;
      underflow <= ext_p & ~ent_p & empty;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_gate
    gate_state_t   state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          open_q;

    always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      case (state_q)
        CLOSED: if (acc[g]) begin
          state_d = OPEN;
          tmr_d   = OPEN_LD;
        end
        OPEN: begin
          if (acc[g]) tmr_d = OPEN_LD;
          else if (tmr_q == '0) begin
            state_d = CLOSING;
            tmr_d   = CLOSE_LD;
          end else tmr_d = tmr_q - TW'(1);
        end
        CLOSING: begin
          if (acc[g]) begin
            state_d = OPEN;
            tmr_d   = OPEN_LD;
          end else if (tmr_q == '0) state_d = CLOSED;
          else tmr_d = tmr_q - TW'(1);
        end
        default: begin
          state_d = CLOSED;
          tmr_d   = '0;
        end
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= CLOSED;
        tmr_q   <= '0;
        open_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        tmr_q   <= tmr_d;
        open_q  <= (state_d == OPEN);
      end
    end

    assign gate_open[g] = open_q;
  end

  assign entry_gate_open = gate_open[0];
  assign exit_gate_open  = gate_open[1];

endmodule
